alu_exec_stage: RTL



---
 rtl/alu_exec_stage_if.sv | 28 ++
 rtl/alu_exec_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between the shifter-side producer and the ALU execute stage.
// master drives operations and out_ready; slave is the stage itself.
interface alu_exec_stage_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [1:0]       aluop;
  logic             loads;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c_out;
  logic [2:0]       status;
  logic [CNT_W-1:0] ops_done;

  modport master (
    output in_valid, ain, bin, aluop, loads, out_ready,
    input  in_ready, out_valid, c_out, status, ops_done
  );

  modport slave (
    input  in_valid, ain, bin, aluop, loads, out_ready,
    output in_ready, out_valid, c_out, status, ops_done
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage (ADD/SUB/AND/NOT) into a 2-entry skid buffer; 1-cycle latency, in_ready from state only.
// Backpressure: holds up to two results while out_ready is low. ALU_SAT_EN enables ADD/SUB saturation.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  alu_exec_stage_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
  } flags_t;

  state_t           state;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] s_q;
  logic             vld_q;
  logic             rdy_q;
  flags_t           status_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] r;
  logic             ovf;
  flags_t           flags;
  logic             accept;
  logic             pop;

  assign accept = bus.in_valid & rdy_q;
  assign pop    = vld_q & bus.out_ready;

  always_comb begin
    raw = '0;
    ovf = 1'b0;
    unique case (bus.aluop)
      2'b00: begin
        raw = bus.ain + bus.bin;
        ovf = (bus.ain[MSB] == bus.bin[MSB]) & (raw[MSB] != bus.ain[MSB]);
      end
      2'b01: begin
        raw = bus.ain - bus.bin;
        ovf = (bus.ain[MSB] != bus.bin[MSB]) & (raw[MSB] != bus.ain[MSB]);
      end
      2'b10:   raw = bus.ain & bus.bin;
      default: raw = ~bus.bin;
    endcase
    r = raw;
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of ain for both ADD and SUB.
    if (ovf) r = bus.ain[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    flags.v = ovf;
    flags.n = r[MSB];
    flags.z = (r == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      m_q      <= '0;
      s_q      <= '0;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b1;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept && bus.loads) status_q <= flags;
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
      unique case (state)
        EMPTY: begin
          if (accept) begin
            m_q   <= r;
            state <= ONE;
            vld_q <= 1'b1;
          end
        end
        ONE: begin
          unique case ({accept, pop})
            2'b11: m_q <= r;
            2'b10: begin
              s_q   <= r;
              state <= FULL;
              rdy_q <= 1'b0;
            end
            2'b01: begin
              state <= EMPTY;
              vld_q <= 1'b0;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            m_q   <= s_q;
            state <= ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.c_out     = m_q;
  assign bus.status    = status_q;
  assign bus.ops_done  = cnt_q;
endmodule
